// File: rtl/sa_aw_channel.sv
// Slave-arbiter AW stage: picks one dispatcher per grant (round-robin by default,
// lowest index first when SA_AW_FIXED_PRIORITY_EN is defined), registers the beat
// toward the slave with the master index prefixed to AWID, and pushes
// {master index, AWLEN} to the WDATA order FIFO in the grant cycle.
// Latency: 1 cycle from the dispatcher handshake to s_AWvalid_o. Throughput is
// 1 AW/cycle while s_AWready_i=1.
// Backpressure: a grant needs a free or draining output slot and no W_stall_i.
module sa_aw_channel #(
  parameter int MST_AMT           = 3,
  parameter int MST_ID_W          = $clog2(MST_AMT),
  parameter int TRANS_MST_ID_W    = 5,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_BURST_W     = 2,
  parameter int TRANS_DATA_LEN_W  = 3,
  parameter int TRANS_DATA_SIZE_W = 3
) (
  input  logic                                  ACLK_i,
  input  logic                                  ARESETn_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     dsp_AWid_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]         dsp_AWaddr_i,
  input  logic [TRANS_BURST_W*MST_AMT-1:0]      dsp_AWburst_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   dsp_AWlen_i,
  input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]  dsp_AWsize_i,
  input  logic [MST_AMT-1:0]                    dsp_AWvalid_i,
  input  logic [MST_AMT-1:0]                    dsp_slv_sel_i,
  output logic [MST_AMT-1:0]                    dsp_AWready_o,
  output logic [MST_ID_W+TRANS_MST_ID_W-1:0]    s_AWid_o,
  output logic [ADDR_WIDTH-1:0]                 s_AWaddr_o,
  output logic [TRANS_BURST_W-1:0]              s_AWburst_o,
  output logic [TRANS_DATA_LEN_W-1:0]           s_AWlen_o,
  output logic [TRANS_DATA_SIZE_W-1:0]          s_AWsize_o,
  output logic                                  s_AWvalid_o,
  input  logic                                  s_AWready_i,
  output logic [MST_ID_W-1:0]                   W_mst_id_o,
  output logic [TRANS_DATA_LEN_W-1:0]           W_AxLEN_o,
  output logic                                  W_fifo_order_wr_en_o,
  input  logic                                  W_stall_i
);

  typedef struct packed {
    logic [MST_ID_W+TRANS_MST_ID_W-1:0] id;
    logic [ADDR_WIDTH-1:0]              addr;
    logic [TRANS_BURST_W-1:0]           burst;
    logic [TRANS_DATA_LEN_W-1:0]        len;
    logic [TRANS_DATA_SIZE_W-1:0]       size;
  } aw_beat_t;

  logic [MST_AMT-1:0]          req;
  logic                        can_accept;
  logic                        grant_hit;
  logic                        grant_fire;
  logic [MST_ID_W-1:0]         grant_idx;
  logic [TRANS_MST_ID_W-1:0]   sel_id;
  logic [ADDR_WIDTH-1:0]       sel_addr;
  logic [TRANS_BURST_W-1:0]    sel_burst;
  logic [TRANS_DATA_LEN_W-1:0] sel_len;
  logic [TRANS_DATA_SIZE_W-1:0] sel_size;
  aw_beat_t                    beat_q, beat_d;
  logic                        valid_q, valid_d;

  assign req        = dsp_AWvalid_i & dsp_slv_sel_i;
  assign can_accept = ~valid_q | s_AWready_i;
  // Gated by the reset input so no ready or FIFO push can leak out while reset is held.
  assign grant_fire = ARESETn_i & can_accept & ~W_stall_i & grant_hit;

`ifdef SA_AW_FIXED_PRIORITY_EN
  // Fixed priority: scan downwards so the lowest requesting index is the last write and wins.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    for (int i = MST_AMT - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_hit = 1'b1;
        grant_idx = MST_ID_W'(i);
      end
    end
  end
`else
  logic [MST_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  int                  scan_idx;

  // Round-robin: scan offsets downwards so the smallest offset from rr_ptr wins.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int k = MST_AMT - 1; k >= 0; k--) begin
      scan_idx = (int'(rr_ptr_q) + k) % MST_AMT;
      if (req[scan_idx]) begin
        grant_hit = 1'b1;
        grant_idx = MST_ID_W'(scan_idx);
      end
    end
  end

  // The pointer moves just past the winner, wrapping at the last master.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_fire) begin
      rr_ptr_d = (grant_idx == MST_ID_W'(MST_AMT - 1)) ? '0 : grant_idx + MST_ID_W'(1);
    end
  end

  // Pointer state; reset returns it to master 0 immediately.
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) rr_ptr_q <= '0;
    else            rr_ptr_q <= rr_ptr_d;
  end
`endif

  // Pick the granted master's fields out of the packed per-master buses.
  always_comb begin
    sel_id    = dsp_AWid_i   [int'(grant_idx)*TRANS_MST_ID_W    +: TRANS_MST_ID_W];
    sel_addr  = dsp_AWaddr_i [int'(grant_idx)*ADDR_WIDTH        +: ADDR_WIDTH];
    sel_burst = dsp_AWburst_i[int'(grant_idx)*TRANS_BURST_W     +: TRANS_BURST_W];
    sel_len   = dsp_AWlen_i  [int'(grant_idx)*TRANS_DATA_LEN_W  +: TRANS_DATA_LEN_W];
    sel_size  = dsp_AWsize_i [int'(grant_idx)*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
  end

  // Ready and order-FIFO push are combinational so they coincide with the handshake.
  always_comb begin
    dsp_AWready_o        = grant_fire ? (MST_AMT'(1) << grant_idx) : '0;
    W_fifo_order_wr_en_o = grant_fire;
    W_mst_id_o           = grant_idx;
    W_AxLEN_o            = sel_len;
  end

  // Output slot: load on grant (refilling even while draining), clear on drain, else hold.
  always_comb begin
    beat_d  = beat_q;
    valid_d = valid_q;
    if (grant_fire) begin
      beat_d.id    = {grant_idx, sel_id};
      beat_d.addr  = sel_addr;
      beat_d.burst = sel_burst;
      beat_d.len   = sel_len;
      beat_d.size  = sel_size;
      valid_d      = 1'b1;
    end else if (s_AWready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output register; reset drops any held beat immediately.
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      beat_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      valid_q <= valid_d;
    end
  end

  assign s_AWvalid_o = valid_q;
  assign s_AWid_o    = beat_q.id;
  assign s_AWaddr_o  = beat_q.addr;
  assign s_AWburst_o = beat_q.burst;
  assign s_AWlen_o   = beat_q.len;
  assign s_AWsize_o  = beat_q.size;

endmodule
